tgt_ddr_tx_seq: RTL and testbench

Target-side HDR-DDR read-response sequencer. It drives the target TX serializer's enable/mode handshake and steps it through this frame:
- ACK or NACK preamble
- N data words, each: follow preamble, high byte, low byte, parity
- CRC preamble, CRC token, CRC value

It addresses the register file for each byte and reports completion to the DDR CCC/engine layer. It sits between the target engine and the TX serializer.

---
 rtl/tgt_ddr_pkg.sv | 53 +++++
 rtl/tgt_ddr_tx_seq.sv | 170 +++++++++++++++++
 tb/tb_tgt_ddr_tx_seq.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tgt_ddr_pkg.sv
// Shared definitions for the target HDR-DDR TX path: serializer mode codes,
// read-response sequencer states and frame status codes.
package tgt_ddr_pkg;

   // Serializer mode codes (also decoded by the TX serializer)
   localparam logic [2:0] MODE_PRE_ZERO  = 3'b000;
   localparam logic [2:0] MODE_PRE_ONE   = 3'b001;
   localparam logic [2:0] MODE_CRC_TOKEN = 3'b010;
   localparam logic [2:0] MODE_SER_BYTE  = 3'b011;
   localparam logic [2:0] MODE_PARITY    = 3'b110;
   localparam logic [2:0] MODE_CRC_VALUE = 3'b111;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ACK,
      ST_NACK,
      ST_PRE_DATA,
      ST_BYTE_HI,
      ST_BYTE_LO,
      ST_PARITY,
      ST_CRC_PRE,
      ST_CRC_TOK,
      ST_CRC_VAL,
      ST_FINISH
   } seq_state_e;

   typedef enum logic [1:0] {
      STAT_OK    = 2'b00,
      STAT_NACK  = 2'b01,
      STAT_ABORT = 2'b10,
      STAT_ZERO  = 2'b11
   } seq_status_e;

   // Mode presented to the serializer while in a given state
   function automatic logic [2:0] mode_of(seq_state_e s);
      logic [2:0] m;
      m = MODE_PRE_ZERO;
      case (s)
         ST_ACK:      m = MODE_PRE_ZERO;
         ST_NACK:     m = MODE_PRE_ONE;
         ST_PRE_DATA: m = MODE_PRE_ONE;
         ST_BYTE_HI:  m = MODE_SER_BYTE;
         ST_BYTE_LO:  m = MODE_SER_BYTE;
         ST_PARITY:   m = MODE_PARITY;
         ST_CRC_PRE:  m = MODE_PRE_ZERO;
         ST_CRC_TOK:  m = MODE_CRC_TOKEN;
         ST_CRC_VAL:  m = MODE_CRC_VALUE;
         default:     m = MODE_PRE_ZERO;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/tgt_ddr_tx_seq.sv
// Target-side HDR-DDR read-response sequencer. Steps the TX serializer
// through ACK/NACK preamble, N data words (preamble, hi, lo, parity) and
// the CRC trailer, addressing the register file for each data byte.
// Optional: define TGT_ABORT_EN to let i_abort end the frame at a data
// preamble (status 10, CRC skipped).
module tgt_ddr_tx_seq
   import tgt_ddr_pkg::*;
#(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned WCNT_W = 8
) (
   input  logic              i_sys_clk,
   input  logic              i_sys_rst,
   input  logic              i_eng_start,
   input  logic              i_eng_nack,
   input  logic [ADDR_W-1:0] i_eng_base_addr,
   input  logic [WCNT_W-1:0] i_eng_word_cnt,
   input  logic              i_tx_mode_done,
   input  logic              i_abort,
   output logic              o_tx_en,
   output logic [2:0]        o_tx_mode,
   output logic              o_regf_rd_en,
   output logic [ADDR_W-1:0] o_regf_addr,
   output logic              o_crc_init,
   output logic              o_busy,
   output logic              o_done,
   output logic [1:0]        o_status
);

   seq_state_e        state_q, state_d;
   seq_status_e       status_q, status_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [WCNT_W-1:0] wcnt_q, wcnt_d;
   logic [WCNT_W-1:0] cnt_q, cnt_d;
   logic              tx_en_q, tx_en_d;
   logic [2:0]        mode_q, mode_d;
   logic              rd_en_q, rd_en_d;
   logic              crc_init_q, crc_init_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

`ifndef TGT_ABORT_EN
   logic unused_abort;
   assign unused_abort = i_abort;
`endif

   // Next-state, counter updates and registered-output precompute
   always_comb begin
      state_d    = state_q;
      status_d   = status_q;
      addr_d     = addr_q;
      wcnt_d     = wcnt_q;
      cnt_d      = cnt_q;
      crc_init_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (i_eng_start) begin
               addr_d     = i_eng_base_addr;
               cnt_d      = i_eng_word_cnt;
               wcnt_d     = '0;
               crc_init_d = 1'b1;
               if (i_eng_nack) begin
                  status_d = STAT_OK;
                  state_d  = ST_NACK;
               end else if (i_eng_word_cnt == '0) begin
                  status_d = STAT_ZERO;
                  state_d  = ST_ACK;
               end else begin
                  status_d = STAT_OK;
                  state_d  = ST_ACK;
               end
            end
         end
         ST_ACK: begin
            if (i_tx_mode_done)
               state_d = (status_q == STAT_ZERO) ? ST_CRC_PRE : ST_PRE_DATA;
         end
         ST_NACK: begin
            if (i_tx_mode_done) begin
               state_d  = ST_FINISH;
               status_d = STAT_NACK;
            end
         end
         ST_PRE_DATA: begin
            if (i_tx_mode_done) begin
`ifdef TGT_ABORT_EN
               if (i_abort) begin
                  state_d  = ST_FINISH;
                  status_d = STAT_ABORT;
               end else begin
                  state_d = ST_BYTE_HI;
               end
`else
               state_d = ST_BYTE_HI;
`endif
            end
         end
         ST_BYTE_HI: begin
            if (i_tx_mode_done) begin
               state_d = ST_BYTE_LO;
               addr_d  = addr_q + ADDR_W'(1);
            end
         end
         ST_BYTE_LO: begin
            if (i_tx_mode_done) begin
               state_d = ST_PARITY;
               addr_d  = addr_q + ADDR_W'(1);
               wcnt_d  = wcnt_q + WCNT_W'(1);
            end
         end
         ST_PARITY: begin
            if (i_tx_mode_done)
               state_d = (wcnt_q < cnt_q) ? ST_PRE_DATA : ST_CRC_PRE;
         end
         ST_CRC_PRE: if (i_tx_mode_done) state_d = ST_CRC_TOK;
         ST_CRC_TOK: if (i_tx_mode_done) state_d = ST_CRC_VAL;
         ST_CRC_VAL: if (i_tx_mode_done) state_d = ST_FINISH;
         ST_FINISH:  state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase

      // Outputs are registered from the upcoming state, so they change
      // together with the state and never glitch toward the serializer.
      tx_en_d = !(state_d inside {ST_IDLE, ST_FINISH});
      mode_d  = mode_of(state_d);
      rd_en_d = (state_d inside {ST_BYTE_HI, ST_BYTE_LO});
      done_d  = (state_d == ST_FINISH);
      busy_d  = tx_en_d;
   end

   // State, counters and output registers with async active-low reset
   always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
      if (!i_sys_rst) begin
         state_q    <= ST_IDLE;
         status_q   <= STAT_OK;
         addr_q     <= '0;
         wcnt_q     <= '0;
         cnt_q      <= '0;
         tx_en_q    <= 1'b0;
         mode_q     <= MODE_PRE_ZERO;
         rd_en_q    <= 1'b0;
         crc_init_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         status_q   <= status_d;
         addr_q     <= addr_d;
         wcnt_q     <= wcnt_d;
         cnt_q      <= cnt_d;
         tx_en_q    <= tx_en_d;
         mode_q     <= mode_d;
         rd_en_q    <= rd_en_d;
         crc_init_q <= crc_init_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign o_tx_en      = tx_en_q;
   assign o_tx_mode    = mode_q;
   assign o_regf_rd_en = rd_en_q;
   assign o_regf_addr  = addr_q;
   assign o_crc_init   = crc_init_q;
   assign o_busy       = busy_q;
   assign o_done       = done_q;
   assign o_status     = status_q;

endmodule

// File: tb/tb_tgt_ddr_tx_seq.sv
// Self-checking bench for tgt_ddr_tx_seq: a serializer responder issues
// done pulses after random stalls, and each observed mode/address is
// compared against a scoreboard built from the frame format.
`timescale 1ns/1ps
module tb_tgt_ddr_tx_seq;

   localparam int unsigned ADDR_W = 10;
   localparam int unsigned WCNT_W = 8;
`ifdef TGT_ABORT_EN
   localparam bit ABORT_ON = 1'b1;
`else
   localparam bit ABORT_ON = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              nack = 1'b0;
   logic [ADDR_W-1:0] base = '0;
   logic [WCNT_W-1:0] cnt = '0;
   logic              mdone = 1'b0;
   logic              abort = 1'b0;
   logic              tx_en;
   logic [2:0]        tx_mode;
   logic              rd_en;
   logic [ADDR_W-1:0] raddr;
   logic              crc_init;
   logic              busy;
   logic              fdone;
   logic [1:0]        status;

   int checks = 0;
   int errors = 0;

   logic [2:0]        exp_mode_q[$];
   logic [ADDR_W-1:0] exp_addr_q[$];
   logic [1:0]        exp_status;
   int                exp_abort_idx;

   always #5 clk = ~clk;

   tgt_ddr_tx_seq #(.ADDR_W(ADDR_W), .WCNT_W(WCNT_W)) dut (
      .i_sys_clk      (clk),
      .i_sys_rst      (rst_n),
      .i_eng_start    (start),
      .i_eng_nack     (nack),
      .i_eng_base_addr(base),
      .i_eng_word_cnt (cnt),
      .i_tx_mode_done (mdone),
      .i_abort        (abort),
      .o_tx_en        (tx_en),
      .o_tx_mode      (tx_mode),
      .o_regf_rd_en   (rd_en),
      .o_regf_addr    (raddr),
      .o_crc_init     (crc_init),
      .o_busy         (busy),
      .o_done         (fdone),
      .o_status       (status)
   );

   // Scoreboard fill: expected mode/address stream for one frame
   task automatic build_expect(input logic nack_v, input logic [ADDR_W-1:0] b,
                               input logic [WCNT_W-1:0] c, input int abort_word);
      logic [ADDR_W-1:0] a;
      bit stop;
      exp_mode_q.delete();
      exp_addr_q.delete();
      exp_abort_idx = -1;
      a = b;
      stop = 1'b0;
      if (nack_v) begin
         exp_mode_q.push_back(3'b001);
         exp_status = 2'b01;
      end else begin
         exp_mode_q.push_back(3'b000);
         for (int unsigned w = 0; w < c && !stop; w++) begin
            exp_mode_q.push_back(3'b001);
            if (abort_word == int'(w) + 1) begin
               exp_abort_idx = exp_mode_q.size() - 1;
               stop = ABORT_ON;
            end
            if (!stop) begin
               exp_mode_q.push_back(3'b011); exp_addr_q.push_back(a); a = a + ADDR_W'(1);
               exp_mode_q.push_back(3'b011); exp_addr_q.push_back(a); a = a + ADDR_W'(1);
               exp_mode_q.push_back(3'b110);
            end
         end
         if (stop) begin
            exp_status = 2'b10;
         end else begin
            exp_mode_q.push_back(3'b000);
            exp_mode_q.push_back(3'b010);
            exp_mode_q.push_back(3'b111);
            exp_status = (c == '0) ? 2'b11 : 2'b00;
         end
      end
   endtask

   // Runs one frame; rst_at/start_at are step indices (-1 = unused)
   task automatic run_frame(input logic nack_v, input logic [ADDR_W-1:0] b,
                            input logic [WCNT_W-1:0] c, input int abort_word,
                            input int unsigned max_wait, input int rst_at, input int start_at);
      logic [2:0]        m;
      logic [ADDR_W-1:0] a;
      int unsigned       nw;
      int                idx;
      build_expect(nack_v, b, c, abort_word);
      @(negedge clk);
      start = 1'b1; nack = nack_v; base = b; cnt = c;
      @(negedge clk);
      start = 1'b0; nack = 1'b0;
      base = ADDR_W'($urandom); cnt = WCNT_W'($urandom);
      checks++;
      if (crc_init !== 1'b1 || busy !== 1'b1 || tx_en !== 1'b1)
         begin errors++; $display("FAIL start_resp crc_init=%b busy=%b tx_en=%b exp 1 1 1", crc_init, busy, tx_en); end
      idx = 0;
      while (exp_mode_q.size() > 0) begin
         m = exp_mode_q.pop_front();
         nw = $urandom_range(0, max_wait);
         for (int unsigned w = 0; w < nw; w++) begin
            checks++;
            if (tx_en !== 1'b1 || tx_mode !== m)
               begin errors++; $display("FAIL mode_hold idx=%0d tx_en=%b mode=%b exp mode=%b", idx, tx_en, tx_mode, m); end
            @(negedge clk);
         end
         if (idx == rst_at) begin
            rst_n = 1'b0;
            #1;
            checks++;
            if ({tx_en, tx_mode, rd_en, raddr, crc_init, busy, fdone, status} !== '0)
               begin errors++; $display("FAIL async_reset tx_en=%b mode=%b rd=%b addr=%h crc=%b busy=%b done=%b st=%b exp all 0",
                                        tx_en, tx_mode, rd_en, raddr, crc_init, busy, fdone, status); end
            exp_mode_q.delete();
            exp_addr_q.delete();
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            return;
         end
         checks++;
         if (tx_en !== 1'b1 || tx_mode !== m || (idx > 0 && crc_init !== 1'b0) || busy !== 1'b1)
            begin errors++; $display("FAIL mode idx=%0d tx_en=%b mode=%b crc=%b busy=%b exp mode=%b", idx, tx_en, tx_mode, crc_init, busy, m); end
         if (m == 3'b011) begin
            a = (exp_addr_q.size() > 0) ? exp_addr_q.pop_front() : 'x;
            checks++;
            if (rd_en !== 1'b1 || raddr !== a)
               begin errors++; $display("FAIL regf idx=%0d rd_en=%b addr=%h exp rd_en=1 addr=%h", idx, rd_en, raddr, a); end
         end else begin
            checks++;
            if (rd_en !== 1'b0)
               begin errors++; $display("FAIL rd_en_off idx=%0d rd_en=%b exp 0", idx, rd_en); end
         end
         mdone = 1'b1;
         if (idx == exp_abort_idx) abort = 1'b1;
         if (idx == start_at) begin
            start = 1'b1; nack = 1'b1; base = 10'h2AA; cnt = 8'd5;
         end
         @(negedge clk);
         mdone = 1'b0; abort = 1'b0; start = 1'b0; nack = 1'b0;
         idx++;
      end
      checks++;
      if (fdone !== 1'b1 || tx_en !== 1'b0 || busy !== 1'b0 || status !== exp_status)
         begin errors++; $display("FAIL finish done=%b tx_en=%b busy=%b status=%b exp 1 0 0 %b", fdone, tx_en, busy, status, exp_status); end
      @(negedge clk);
      checks++;
      if (fdone !== 1'b0 || tx_en !== 1'b0 || busy !== 1'b0 || crc_init !== 1'b0 || status !== exp_status)
         begin errors++; $display("FAIL idle_after done=%b tx_en=%b busy=%b crc=%b status=%b exp 0 0 0 0 %b", fdone, tx_en, busy, crc_init, status, exp_status); end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({tx_en, tx_mode, rd_en, raddr, crc_init, busy, fdone, status} !== '0)
         begin errors++; $display("FAIL reset_values got=%h exp 0", {tx_en, tx_mode, rd_en, raddr, crc_init, busy, fdone, status}); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_ack_frame();
      run_frame(1'b0, 10'h010, 8'd2, 0, 2, -1, -1);
   endtask

   task automatic test_nack();
      run_frame(1'b1, 10'h055, 8'd4, 0, 1, -1, -1);
   endtask

   task automatic test_zero_count();
      run_frame(1'b0, 10'h123, 8'd0, 0, 1, -1, -1);
   endtask

   task automatic test_addr_wrap();
      run_frame(1'b0, 10'h3FF, 8'd1, 0, 1, -1, -1);
   endtask

   task automatic test_start_while_busy();
      run_frame(1'b0, 10'h040, 8'd2, 0, 1, -1, 3);
   endtask

   task automatic test_idle_done();
      for (int i = 0; i < 3; i++) begin
         mdone = 1'b1;
         @(negedge clk);
         checks++;
         if (tx_en !== 1'b0 || busy !== 1'b0 || tx_mode !== 3'b000 || rd_en !== 1'b0 || fdone !== 1'b0)
            begin errors++; $display("FAIL idle_done tx_en=%b busy=%b mode=%b rd=%b done=%b exp all 0", tx_en, busy, tx_mode, rd_en, fdone); end
      end
      mdone = 1'b0;
   endtask

   task automatic test_reset_mid_frame();
      run_frame(1'b0, 10'h100, 8'd3, 0, 1, 7, -1);
      run_frame(1'b0, 10'h200, 8'd3, 0, 1, -1, -1);
   endtask

   task automatic test_abort();
      run_frame(1'b0, 10'h080, 8'd3, 2, 1, -1, -1);
   endtask

   task automatic test_max_count();
      run_frame(1'b0, 10'h300, 8'd255, 0, 0, -1, -1);
   endtask

   initial begin
      test_reset();
      test_ack_frame();
      test_nack();
      test_zero_count();
      test_addr_wrap();
      test_start_while_busy();
      test_idle_done();
      test_reset_mid_frame();
      test_abort();
      test_max_count();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Hard stop in case the sequencing above stalls
   initial begin
      #2000000;
      $display("FAIL timeout reached exp finish before 2000000ns");
      $fatal(1, "timeout");
   end

endmodule
